// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the hazard controller and the decode/execute and
// writeback/memory stages: instructions and memory handshake in, controls out.
interface pipeline_hazard_ctrl_if #(
    parameter int PERF_W = 32
);
    logic [31:0]       instr_de;
    logic [31:0]       instr_mw;
    logic              br_taken;
    logic              dmem_ack;
    logic              stall;
    logic              flush;
    logic              forw_a;
    logic              forw_b;
    logic              reg_wr;
    logic              dmem_req;
    logic              dmem_we;
    logic              mem_err;
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;

    modport master (
        output instr_de, instr_mw, br_taken, dmem_ack,
        input  stall, flush, forw_a, forw_b, reg_wr,
        input  dmem_req, dmem_we, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  instr_de, instr_mw, br_taken, dmem_ack,
        output stall, flush, forw_a, forw_b, reg_wr,
        output dmem_req, dmem_we, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for a three-stage pipeline: operand forwarding,
// load-use interlock, data-memory handshake with timeout, and perf counters.
module pipeline_hazard_ctrl #(
    parameter int WAIT_MAX = 16,
    parameter int PERF_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  bus
);
    localparam int            CW        = $clog2(WAIT_MAX);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

    localparam logic [4:0] OP_R     = 5'b01100;
    localparam logic [4:0] OP_I     = 5'b00100;
    localparam logic [4:0] OP_LD    = 5'b00000;
    localparam logic [4:0] OP_ST    = 5'b01000;
    localparam logic [4:0] OP_BR    = 5'b11000;
    localparam logic [4:0] OP_JAL   = 5'b11011;
    localparam logic [4:0] OP_JALR  = 5'b11001;
    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_AUIPC = 5'b00101;

    typedef enum logic [1:0] {RUN, MEM_WAIT, LD_USE} state_t;

    function automatic logic f_writes_rd(input logic [4:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_JAL) ||
               (op == OP_JALR) || (op == OP_LUI) || (op == OP_AUIPC);
    endfunction

    function automatic logic f_uses_rs1(input logic [4:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_ST) ||
               (op == OP_BR) || (op == OP_JALR);
    endfunction

    function automatic logic f_uses_rs2(input logic [4:0] op);
        return (op == OP_R) || (op == OP_ST) || (op == OP_BR);
    endfunction

    state_t            r_state;
    state_t            w_state_next;
    logic [CW-1:0]     r_wait_cnt;
    logic [CW-1:0]     w_wait_next;
    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_flush_cnt;

    logic [4:0] w_op_de;
    logic [4:0] w_op_mw;
    logic [4:0] w_rd_mw;
    logic       w_bubble;
    logic       w_wr_mw;
    logic       w_ld_mw;
    logic       w_st_mw;
    logic       w_mem_mw;
    logic       w_hit_rs1;
    logic       w_hit_rs2;
    logic       w_dep;
    logic       w_redirect;
    logic       w_stall;
    logic       w_flush;
    logic       w_forw_a;
    logic       w_forw_b;
    logic       w_reg_wr;
    logic       w_req;
    logic       w_we;
    logic       w_err;
    logic       w_unused;

    assign w_op_de   = bus.instr_de[6:2];
    assign w_op_mw   = bus.instr_mw[6:2];
    assign w_rd_mw   = bus.instr_mw[11:7];
    assign w_bubble  = (bus.instr_mw == 32'h0000_0000);
    assign w_wr_mw   = !w_bubble && f_writes_rd(w_op_mw) && (w_rd_mw != 5'd0);
    assign w_ld_mw   = !w_bubble && (w_op_mw == OP_LD);
    assign w_st_mw   = !w_bubble && (w_op_mw == OP_ST);
    assign w_mem_mw  = w_ld_mw || w_st_mw;
    assign w_hit_rs1 = f_uses_rs1(w_op_de) && (bus.instr_de[19:15] == w_rd_mw);
    assign w_hit_rs2 = f_uses_rs2(w_op_de) && (bus.instr_de[24:20] == w_rd_mw);
    assign w_dep     = w_ld_mw && w_wr_mw && (w_hit_rs1 || w_hit_rs2);
    assign w_unused  = &{1'b0, bus.instr_de[31:25], bus.instr_de[14:7], bus.instr_de[1:0]};

    // The ALU pipeline register holds a load's address, never its data.
    assign w_forw_a = w_wr_mw && !w_ld_mw && w_hit_rs1 && (r_state != LD_USE);
    assign w_forw_b = w_wr_mw && !w_ld_mw && w_hit_rs2 && (r_state != LD_USE);

    assign w_redirect = ((w_op_de == OP_BR) && bus.br_taken) ||
                        (w_op_de == OP_JAL) || (w_op_de == OP_JALR);
    assign w_flush    = w_redirect && !w_stall;

    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait_cnt;
        w_stall      = 1'b0;
        w_reg_wr     = 1'b0;
        w_req        = 1'b0;
        w_we         = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            RUN: begin
                w_req = w_mem_mw;
                w_we  = w_st_mw;
                if (w_mem_mw && !bus.dmem_ack) begin
                    w_stall      = 1'b1;
                    w_wait_next  = CW'(1);
                    w_state_next = MEM_WAIT;
                end else if (w_dep) begin
                    w_reg_wr     = 1'b1;
                    w_stall      = 1'b1;
                    w_state_next = LD_USE;
                end else begin
                    w_reg_wr = w_wr_mw;
                end
            end
            MEM_WAIT: begin
                w_req   = 1'b1;
                w_we    = w_st_mw;
                w_stall = 1'b1;
                if (bus.dmem_ack) begin
                    w_reg_wr    = w_wr_mw;
                    w_wait_next = '0;
                    if (w_dep) begin
                        w_state_next = LD_USE;
                    end else begin
                        w_stall      = 1'b0;
                        w_state_next = RUN;
                    end
                end else if (r_wait_cnt == WAIT_LAST) begin
                    // Give up: the instruction retires without effect.
                    w_err        = 1'b1;
                    w_stall      = 1'b0;
                    w_wait_next  = '0;
                    w_state_next = RUN;
                end else begin
                    w_wait_next = r_wait_cnt + CW'(1);
                end
            end
            LD_USE: begin
                w_state_next = RUN;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + PERF_W'(1);
            end
        end
    end

    // Combinational controls are held low for the whole reset window.
    assign bus.stall     = rst && w_stall;
    assign bus.flush     = rst && w_flush;
    assign bus.forw_a    = rst && w_forw_a;
    assign bus.forw_b    = rst && w_forw_b;
    assign bus.reg_wr    = rst && w_reg_wr;
    assign bus.dmem_req  = rst && w_req;
    assign bus.dmem_we   = rst && w_we;
    assign bus.mem_err   = rst && w_err;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, directed
// multi-cycle sequences, and randomized traffic against a reference model.
module tb_pipeline_hazard_ctrl;
    localparam int WAIT_MAX = 4;
    localparam int PERF_W   = 4;
    localparam int CNT_MAX  = (1 << PERF_W) - 1;

    localparam logic [4:0] OP_R     = 5'b01100;
    localparam logic [4:0] OP_I     = 5'b00100;
    localparam logic [4:0] OP_LD    = 5'b00000;
    localparam logic [4:0] OP_ST    = 5'b01000;
    localparam logic [4:0] OP_BR    = 5'b11000;
    localparam logic [4:0] OP_JAL   = 5'b11011;
    localparam logic [4:0] OP_JALR  = 5'b11001;
    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_AUIPC = 5'b00101;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    pipeline_hazard_ctrl_if #(.PERF_W(PERF_W)) bus ();

    pipeline_hazard_ctrl #(
        .WAIT_MAX (WAIT_MAX),
        .PERF_W   (PERF_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // {stall, flush, forw_a, forw_b, reg_wr, dmem_req, dmem_we, mem_err}
    logic [7:0] outs;
    assign outs = {bus.stall, bus.flush, bus.forw_a, bus.forw_b,
                   bus.reg_wr, bus.dmem_req, bus.dmem_we, bus.mem_err};

    typedef struct {
        logic [31:0] de;
        logic [31:0] mw;
        logic        br;
        logic        ack;
        logic [7:0]  exp;
    } vec_t;

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'h00, rs2, rs1, 3'h0, rd, op, 2'b11};
    endfunction

    function automatic bit writes_rd(input logic [4:0] op);
        return op inside {OP_R, OP_I, OP_LD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    endfunction

    function automatic bit uses_rs1(input logic [4:0] op);
        return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JALR};
    endfunction

    function automatic bit uses_rs2(input logic [4:0] op);
        return op inside {OP_R, OP_ST, OP_BR};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] de, input logic [31:0] mw,
                         input logic br, input logic ack);
        bus.instr_de = de;
        bus.instr_mw = mw;
        bus.br_taken = br;
        bus.dmem_ack = ack;
    endtask

    task automatic do_reset();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [4:0] op;
        case ($urandom_range(0, 10))
            0: op = OP_R;
            1: op = OP_I;
            2: op = OP_LD;
            3: op = OP_ST;
            4: op = OP_BR;
            5: op = OP_JAL;
            6: op = OP_JALR;
            7: op = OP_LUI;
            8: op = OP_AUIPC;
            9: op = 5'($urandom);
            default: return 32'h0;
        endcase
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), op, 2'b11};
    endfunction

    // Reference: wt = cycles the current request has already waited (0 = none
    // outstanding), ldu = the load-use bubble cycle is due now.
    task automatic ref_step(input logic [31:0] de, input logic [31:0] mw,
                            input logic br, input logic ack,
                            inout int wt, inout bit ldu, output logic [7:0] e);
        logic [4:0] opd, opm, rd;
        bit bub, wr, ld, st, h1, h2, dep, redirect;
        bit s, fl, fa, fb, rw, rq, we, er;
        opd = de[6:2];
        opm = mw[6:2];
        rd  = mw[11:7];
        bub = (mw == 32'h0);
        wr  = !bub && writes_rd(opm) && (rd != 5'd0);
        ld  = !bub && (opm == OP_LD);
        st  = !bub && (opm == OP_ST);
        h1  = uses_rs1(opd) && (de[19:15] == rd);
        h2  = uses_rs2(opd) && (de[24:20] == rd);
        dep = ld && wr && (h1 || h2);
        fa  = wr && !ld && h1;
        fb  = wr && !ld && h2;
        s = 0; rw = 0; rq = 0; we = 0; er = 0;
        if (ldu) begin
            fa  = 0;
            fb  = 0;
            ldu = 0;
        end else if (wt > 0) begin
            rq = 1;
            we = st;
            if (ack) begin
                rw = wr;
                wt = 0;
                if (dep) begin
                    s   = 1;
                    ldu = 1;
                end
            end else if (wt == WAIT_MAX - 1) begin
                er = 1;
                wt = 0;
            end else begin
                s = 1;
                wt++;
            end
        end else begin
            rq = ld || st;
            we = st;
            if ((ld || st) && !ack) begin
                s  = 1;
                wt = 1;
            end else if (dep) begin
                rw  = 1;
                s   = 1;
                ldu = 1;
            end else begin
                rw = wr;
            end
        end
        redirect = ((opd == OP_BR) && br) || (opd == OP_JAL) || (opd == OP_JALR);
        fl = redirect && !s;
        e  = {s, fl, fa, fb, rw, rq, we, er};
    endtask

    vec_t vecs[15];

    initial begin
        int         m_wait;
        bit         m_lduse;
        int         m_sc;
        int         m_fc;
        bit         hold;
        logic [31:0] cur_de;
        logic [31:0] cur_mw;
        logic [7:0]  e;
        logic        br;
        logic        ack;

        vecs[0]  = '{enc(OP_R, 6, 5, 5),    enc(OP_R, 5, 1, 2),     1'b0, 1'b0, 8'b0011_1000};
        vecs[1]  = '{enc(OP_R, 6, 0, 0),    enc(OP_R, 0, 1, 2),     1'b0, 1'b0, 8'b0000_0000};
        vecs[2]  = '{enc(OP_ST, 0, 5, 1),   enc(OP_I, 5, 1, 0),     1'b0, 1'b0, 8'b0010_1000};
        vecs[3]  = '{enc(OP_R, 6, 1, 2),    enc(OP_LD, 5, 1, 0),    1'b0, 1'b1, 8'b0000_1100};
        vecs[4]  = '{enc(OP_R, 6, 5, 5),    enc(OP_ST, 5, 1, 2),    1'b0, 1'b1, 8'b0000_0110};
        vecs[5]  = '{enc(OP_BR, 0, 1, 2),   32'h0,                  1'b1, 1'b0, 8'b0100_0000};
        vecs[6]  = '{enc(OP_BR, 0, 1, 2),   32'h0,                  1'b0, 1'b0, 8'b0000_0000};
        vecs[7]  = '{enc(OP_JAL, 1, 0, 0),  32'h0,                  1'b0, 1'b0, 8'b0100_0000};
        vecs[8]  = '{enc(OP_JALR, 1, 5, 0), enc(OP_R, 5, 1, 2),     1'b0, 1'b0, 8'b0110_1000};
        vecs[9]  = '{enc(OP_LUI, 6, 5, 5),  enc(OP_LUI, 5, 0, 0),   1'b0, 1'b0, 8'b0000_1000};
        vecs[10] = '{enc(OP_JAL, 1, 5, 5),  enc(OP_R, 5, 1, 2),     1'b0, 1'b0, 8'b0100_1000};
        vecs[11] = '{enc(OP_R, 6, 5, 5),    enc(5'b11100, 5, 1, 2), 1'b0, 1'b0, 8'b0000_0000};
        vecs[12] = '{enc(OP_BR, 0, 3, 3),   enc(OP_AUIPC, 3, 0, 0), 1'b1, 1'b0, 8'b0111_1000};
        vecs[13] = '{enc(OP_I, 6, 1, 5),    enc(OP_R, 5, 1, 2),     1'b0, 1'b0, 8'b0000_1000};
        vecs[14] = '{enc(OP_R, 6, 5, 1),    enc(OP_LD, 5, 1, 0),    1'b0, 1'b1, 8'b1000_1100};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("reset_outs", 32'(outs), 32'h0);
        chk("reset_stall_cnt", 32'(bus.stall_cnt), 32'h0);
        chk("reset_flush_cnt", 32'(bus.flush_cnt), 32'h0);
        tick();

        // Single-cycle vectors from RUN; the last one enters the load-use bubble
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].de, vecs[i].mw, vecs[i].br, vecs[i].ack);
            @(negedge clk);
            $display("vec %0d de=%h mw=%h br=%0b ack=%0b outs=%b exp=%b",
                     i, vecs[i].de, vecs[i].mw, vecs[i].br, vecs[i].ack, outs, vecs[i].exp);
            chk($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
            tick();
        end

        // Zero-wait load-use
        do_reset();
        drive(enc(OP_I, 8, 7, 0), enc(OP_LD, 7, 1, 0), 1'b0, 1'b1);
        @(negedge clk);
        $display("seq ldu c0 outs=%b", outs);
        chk("ldu_c0", 32'(outs), 32'b1000_1100);
        tick();
        @(negedge clk);
        $display("seq ldu c1 outs=%b stall_cnt=%0d", outs, bus.stall_cnt);
        chk("ldu_c1", 32'(outs), 32'b0000_0000);
        chk("ldu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
        tick();

        // Store with three wait states
        do_reset();
        drive(enc(OP_R, 3, 4, 5), enc(OP_ST, 0, 1, 2), 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            $display("seq st c%0d outs=%b", c, outs);
            chk($sformatf("st_wait_c%0d", c), 32'(outs), 32'b1000_0110);
            tick();
        end
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        $display("seq st c3 outs=%b stall_cnt=%0d", outs, bus.stall_cnt);
        chk("st_ack", 32'(outs), 32'b0000_0110);
        chk("st_stall_cnt", 32'(bus.stall_cnt), 32'd3);
        tick();

        // Taken branch deferred behind a waiting load
        do_reset();
        drive(enc(OP_BR, 0, 2, 3), enc(OP_LD, 7, 1, 0), 1'b1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            $display("seq br c%0d outs=%b", c, outs);
            chk($sformatf("br_wait_c%0d", c), 32'(outs), 32'b1000_0100);
            tick();
        end
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        $display("seq br c2 outs=%b", outs);
        chk("br_ack", 32'(outs), 32'b0100_1100);
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);
        chk("br_stall_cnt", 32'(bus.stall_cnt), 32'd2);
        tick();

        // Timeout of a load that is never acknowledged
        do_reset();
        drive(enc(OP_R, 1, 2, 3), enc(OP_LD, 7, 1, 0), 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            $display("seq to c%0d outs=%b", c, outs);
            chk($sformatf("to_wait_c%0d", c), 32'(outs), 32'b1000_0100);
            tick();
        end
        @(negedge clk);
        $display("seq to c3 outs=%b", outs);
        chk("to_err", 32'(outs), 32'b0000_0101);
        tick();
        drive(32'h0, enc(OP_R, 5, 1, 2), 1'b0, 1'b0);
        @(negedge clk);
        $display("seq to c4 outs=%b", outs);
        chk("to_back_run", 32'(outs), 32'b0000_1000);
        tick();

        // Asynchronous reset while a request is outstanding
        do_reset();
        drive(32'h0, enc(OP_LD, 7, 1, 0), 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_pre_stall_cnt", 32'(bus.stall_cnt), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        $display("seq rst mid outs=%b stall_cnt=%0d", outs, bus.stall_cnt);
        chk("rst_mid_outs", 32'(outs), 32'h0);
        chk("rst_mid_stall_cnt", 32'(bus.stall_cnt), 32'h0);
        bus.instr_mw = 32'h0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        $display("seq rst post outs=%b", outs);
        chk("rst_post_outs", 32'(outs), 32'h0);
        tick();

        // Flush counter saturation
        do_reset();
        drive(enc(OP_JAL, 1, 0, 0), 32'h0, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            $display("seq sat c%0d flush=%0b flush_cnt=%0d", c, bus.flush, bus.flush_cnt);
            chk($sformatf("sat_flush_c%0d", c), 32'(bus.flush), 32'd1);
            chk($sformatf("sat_cnt_c%0d", c), 32'(bus.flush_cnt), 32'((c < CNT_MAX) ? c : CNT_MAX));
            tick();
        end

        // Randomized traffic against the reference model
        do_reset();
        m_wait  = 0;
        m_lduse = 0;
        m_sc    = 0;
        m_fc    = 0;
        hold    = 0;
        cur_de  = 32'h0;
        cur_mw  = 32'h0;
        for (int c = 0; c < 600; c++) begin
            if (!hold) begin
                cur_de = rnd_instr();
                cur_mw = rnd_instr();
            end
            br  = 1'($urandom_range(0, 1));
            ack = ($urandom_range(0, 9) < 4);
            drive(cur_de, cur_mw, br, ack);
            @(negedge clk);
            ref_step(cur_de, cur_mw, br, ack, m_wait, m_lduse, e);
            $display("rnd %0d de=%h mw=%h br=%0b ack=%0b outs=%b exp=%b sc=%0d fc=%0d",
                     c, cur_de, cur_mw, br, ack, outs, e, bus.stall_cnt, bus.flush_cnt);
            chk($sformatf("rnd%0d_outs", c), 32'(outs), 32'(e));
            chk($sformatf("rnd%0d_stall_cnt", c), 32'(bus.stall_cnt), 32'(m_sc));
            chk($sformatf("rnd%0d_flush_cnt", c), 32'(bus.flush_cnt), 32'(m_fc));
            if (e[7]) m_sc = (m_sc < CNT_MAX) ? m_sc + 1 : CNT_MAX;
            if (e[6]) m_fc = (m_fc < CNT_MAX) ? m_fc + 1 : CNT_MAX;
            hold = e[7];
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
